// File: rtl/div_ctrl_pkg.sv
// Shared defines for the iterative divider: state encodings, handshake constants
// and the step-count limit.
package div_ctrl_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  localparam logic [5:0] DivStepLimit = 6'd32;

  // Two's-complement magnitude of a 32-bit operand when treated as signed.
  function automatic logic [31:0] abs_if_signed(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_ctrl.sv
// Multi-cycle restoring divider for the EX stage: one quotient bit per cycle,
// 33 cycles per divide, result held until the requester drops start_i.
module div_ctrl
  import div_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        busy_o,
  output div_state_e  state_o
);

  // Handshake: start_i is a level held by EX until it sees ready_o; ready_o
  // stays high (result_o stable) until the first edge on which start_i is low.

  div_state_e  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [64:0] sr_q, sr_d;
  logic [31:0] divisor_q, divisor_d;
  logic        neg_quot_q, neg_quot_d;
  logic        neg_rem_q, neg_rem_d;
  logic [63:0] result_q, result_d;

  logic [32:0] trial;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;

  // Remainder half (bits 63:32) minus divisor; bit 32 set means it went negative.
  assign trial    = {1'b0, sr_q[63:32]} - {1'b0, divisor_q};
  assign quot_fix = neg_quot_q ? (~sr_q[31:0] + 32'd1) : sr_q[31:0];
  assign rem_fix  = neg_rem_q ? (~sr_q[64:33] + 32'd1) : sr_q[64:33];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    divisor_d  = divisor_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;

    case (state_q)
      DivFree: begin
        if (start_i == DivStart && !annul_i) begin
          state_d    = (opdata2_i == 32'd0) ? DivByZero : DivOn;
          cnt_d      = 6'd0;
          sr_d       = {32'd0, abs_if_signed(opdata1_i, signed_div_i), 1'b0};
          divisor_d  = abs_if_signed(opdata2_i, signed_div_i);
          neg_quot_d = signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
          neg_rem_d  = signed_div_i && opdata1_i[31];
          result_d   = 64'd0;
        end
      end

      DivByZero: begin
        if (annul_i) begin
          state_d = DivFree;
          sr_d    = 65'd0;
        end else begin
          state_d  = DivEnd;
          result_d = 64'd0;
        end
      end

      DivOn: begin
        if (annul_i) begin
          state_d = DivFree;
          cnt_d   = 6'd0;
          sr_d    = 65'd0;
        end else if (cnt_q == DivStepLimit) begin
          state_d  = DivEnd;
          cnt_d    = 6'd0;
          result_d = {rem_fix, quot_fix};
        end else begin
          sr_d  = trial[32] ? {sr_q[63:0], 1'b0} : {trial[31:0], sr_q[31:0], 1'b1};
          cnt_d = cnt_q + 6'd1;
        end
      end

      DivEnd: begin
        if (start_i == DivStop) begin
          state_d  = DivFree;
          result_d = 64'd0;
        end
      end

      default: state_d = DivFree;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= DivFree;
      cnt_q      <= 6'd0;
      sr_q       <= 65'd0;
      divisor_q  <= 32'd0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= 64'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      divisor_q  <= divisor_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
    end
  end

  assign ready_o  = (state_q == DivEnd) ? DivResultReady : DivResultNotReady;
  assign result_o = ready_o ? result_q : 64'd0;
  assign busy_o   = (state_q == DivOn) || (state_q == DivByZero);
  assign state_o  = state_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed divides against an arithmetic
// model, with per-cycle output checks and literal result pins.
module tb_div_ctrl;
  import div_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        signed_div = 1'b0;
  logic [31:0] opdata1 = 32'd0;
  logic [31:0] opdata2 = 32'd0;
  logic        start = 1'b0;
  logic        annul = 1'b0;
  logic [63:0] result;
  logic        ready;
  logic        busy;
  div_state_e  state;

  div_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .signed_div_i(signed_div),
    .opdata1_i   (opdata1),
    .opdata2_i   (opdata2),
    .start_i     (start),
    .annul_i     (annul),
    .result_o    (result),
    .ready_o     (ready),
    .busy_o      (busy),
    .state_o     (state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic        exp_ready = 1'b0;
  logic        exp_busy = 1'b0;
  logic [63:0] exp_result = 64'd0;
  logic [63:0] exp_q[$];
  logic [63:0] last_result = 64'd0;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural model: plain integer division in 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    longint x, y, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'({32'd0, a});
      y = longint'({32'd0, b});
    end
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction

  // scoreboard compare: every cycle, away from the active edge
  always @(negedge clk) begin
    check64("ready_o", {63'd0, ready}, {63'd0, exp_ready});
    check64("busy_o", {63'd0, busy}, {63'd0, exp_busy});
    check64("result_o", result, exp_ready ? exp_result : 64'd0);
    if (ready) last_result = result;
  end

  // driver: annul_step >= 0 cancels after that many steps
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input int hold, input int annul_step, input bit annul_in_end);
    int lat;
    last_result = 64'hDEAD_BEEF_DEAD_BEEF;
    @(negedge clk);
    opdata1 = a; opdata2 = b; signed_div = sgn; start = 1'b1;
    @(posedge clk);
    exp_q.push_back(model(a, b, sgn));
    lat = (b == 32'd0) ? 1 : 33;
    exp_busy = 1'b1;
    if (annul_step >= 0) begin
      repeat (annul_step) @(posedge clk);
      @(negedge clk);
      annul = 1'b1; start = 1'b0;
      @(posedge clk);
      exp_busy = 1'b0;
      void'(exp_q.pop_back());
      @(negedge clk);
      annul = 1'b0;
    end else begin
      repeat (lat) @(posedge clk);
      exp_busy = 1'b0;
      exp_ready = 1'b1;
      exp_result = exp_q.pop_front();
      repeat (hold) begin
        @(negedge clk);
        annul = annul_in_end;
        @(posedge clk);
      end
      @(negedge clk);
      annul = 1'b0; start = 1'b0;
      @(posedge clk);
      exp_ready = 1'b0;
    end
    @(negedge clk);
    check64("state_free", {62'd0, state}, {62'd0, DivFree});
  endtask

  task automatic reset_mid(input logic [31:0] a, input logic [31:0] b, input int steps);
    @(negedge clk);
    opdata1 = a; opdata2 = b; signed_div = 1'b0; start = 1'b1;
    @(posedge clk);
    exp_busy = 1'b1;
    repeat (steps) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    #2 rst = 1'b0;
    #1;
    check64("rst_ready", {63'd0, ready}, 64'd0);
    check64("rst_busy", {63'd0, busy}, 64'd0);
    check64("rst_result", result, 64'd0);
    check64("rst_state", {62'd0, state}, {62'd0, DivFree});
    exp_busy = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    check64("reset_state", {62'd0, state}, {62'd0, DivFree});
    check64("reset_result", result, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run_div(32'd100, 32'd7, 1'b0, 0, -1, 1'b0);
    check64("udiv_100_7", last_result, 64'h00000002_0000000E);
    run_div(32'hFFFF_FF9C, 32'd7, 1'b1, 0, -1, 1'b0);
    check64("sdiv_m100_7", last_result, 64'hFFFFFFFE_FFFFFFF2);
    run_div(32'hFFFF_FFFF, 32'd2, 1'b0, 0, -1, 1'b0);
    check64("udiv_max_2", last_result, 64'h00000001_7FFFFFFF);
    run_div(32'hFFFF_FFFF, 32'd2, 1'b0, 3, -1, 1'b1);
    check64("udiv_hold", last_result, 64'h00000001_7FFFFFFF);
    run_div(32'h1234_5678, 32'd0, 1'b0, 0, -1, 1'b0);
    check64("udiv_by_zero", last_result, 64'd0);
    run_div(32'h8000_0000, 32'd0, 1'b1, 2, -1, 1'b0);
    check64("sdiv_by_zero", last_result, 64'd0);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, -1, 1'b0);
    check64("sdiv_wrap", last_result, 64'h00000000_80000000);
    run_div(32'd100, 32'd7, 1'b0, 0, 10, 1'b0);
    run_div(32'd100, 32'd7, 1'b0, 0, -1, 1'b0);
    check64("after_annul", last_result, 64'h00000002_0000000E);
    run_div(32'd55, 32'd0, 1'b0, 0, 0, 1'b0);
    reset_mid(32'd100, 32'd7, 20);
    run_div(32'd100, 32'd7, 1'b0, 0, -1, 1'b0);
    check64("after_reset", last_result, 64'h00000002_0000000E);

    run_div(32'd7, 32'hFFFF_FFFE, 1'b1, 0, -1, 1'b0);
    check64("sdiv_7_m2", last_result, 64'h00000001_FFFFFFFD);
    run_div(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 1, -1, 1'b0);
    check64("sdiv_m7_m2", last_result, 64'hFFFFFFFF_00000003);
    run_div(32'd5, 32'd9, 1'b0, 0, -1, 1'b0);
    check64("udiv_5_9", last_result, 64'h00000005_00000000);
    run_div(32'hDEAD_BEEF, 32'h0001_0000, 1'b0, 0, -1, 1'b0);
    check64("udiv_shift", last_result, 64'h0000BEEF_0000DEAD);
    run_div(32'h8000_0000, 32'h8000_0000, 1'b0, 0, -1, 1'b0);
    check64("udiv_eq", last_result, 64'h00000000_00000001);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on its rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-low; clears all state whenever low.
REQ-003 signed_div_i  input  1  1 = signed divide (DIV), 0 = unsigned (DIVU); sampled with start_i.
REQ-004 opdata1_i  input  32  dividend; sampled when start_i is accepted.
REQ-005 opdata2_i  input  32  divisor; sampled when start_i is accepted.
REQ-006 start_i  input  1  divide request from EX; level held high until ready_o is seen.
REQ-007 annul_i  input  1  cancel in-flight divide (pipeline flush).
REQ-008 result_o  output  64  {remainder[63:32] -> HI, quotient[31:0] -> LO}.
REQ-009 ready_o  output  1  result_o valid; EX releases its stall request on it.
REQ-010 busy_o  output  1  high in DivByZero and DivOn states.

Function
REQ-011 The block SHALL implement four states: DivFree, DivByZero, DivOn, DivEnd.
REQ-012 DivFree: start_i=1 and annul_i=0 SHALL be accepted; divisor 0 -> DivByZero, else -> DivOn with step counter cleared.
REQ-013 On acceptance of a signed divide, negative operands SHALL be replaced by their two's-complement magnitudes.
REQ-014 DivOn SHALL perform one restoring trial-subtraction step per cycle on a 65-bit shift register: remainder-half minus divisor, keeping the difference and shifting in 1 if non-negative, else shifting in 0.
REQ-015 After 32 steps, the next DivOn edge SHALL apply the sign fix and load result_o, then enter DivEnd.
REQ-016 Sign fix for signed divides: quotient negated iff operand signs differ; remainder takes the sign of the dividend.
REQ-017 Latency: with the request accepted at edge E0, ready_o SHALL first be high after edge E0+33.
REQ-018 DivByZero SHALL go to DivEnd on the next edge with result_o = 0.
REQ-019 Divide-by-zero latency: ready_o SHALL be high after edge E0+1.
REQ-020 DivEnd: ready_o=1 and result_o held stable; transition to DivFree SHALL occur on the first edge with start_i=0.
REQ-021 Outside DivEnd, ready_o SHALL be 0 and result_o SHALL be 0.
REQ-022 In DivOn or DivByZero, annul_i=1 SHALL return to DivFree on the next edge, discard partial state and never assert ready_o.
REQ-023 annul_i SHALL take priority over a step or completion in the same cycle; annul_i in DivEnd SHALL be ignored.
REQ-024 start_i SHALL be ignored in DivOn, DivByZero and DivEnd; no new request is accepted until the block returns to DivFree.
REQ-025 Signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000 (wrap) and remainder 0.

Reset
REQ-026 rst low SHALL force state DivFree, step counter 0, shift register 0, result_o 0, ready_o 0 and busy_o 0.
REQ-027 Reset asserted mid-divide SHALL abort without a result.
REQ-028 After rst rises, the first request SHALL be accepted on the next edge with start_i high.

Structure
REQ-029 The state encodings (DivFree, DivByZero, DivOn, DivEnd) SHALL live in the shared defines file.
REQ-030 The constants DivResultReady/DivResultNotReady and DivStart/DivStop SHALL live in the shared defines file.
REQ-031 The 32-bit step-count limit SHALL live in the shared defines file.
REQ-032 No sub-module is required; the trial subtractor SHALL be inline combinational logic.
REQ-033 EX SHALL derive its stall request from start_i and ready_o; this block SHALL NOT drive the pipeline controller directly.

Verification
REQ-034 Unsigned 100 / 7: ready_o after E0+33; result_o = {0x00000002, 0x0000000E}.
REQ-035 Signed -100 / 7: result_o = {0xFFFFFFFE, 0xFFFFFFF2}.
REQ-036 Unsigned 0xFFFFFFFF / 2: result_o = {0x00000001, 0x7FFFFFFF}.
REQ-037 Unsigned 0xFFFFFFFF / 2, start_i kept high 3 cycles past ready_o: result_o stable throughout; DivFree one edge after start_i drops.
REQ-038 Divide by zero (any dividend): ready_o after E0+1; result_o = 0.
REQ-039 annul_i pulse at step 10: DivFree next edge, ready_o never asserted; an immediate new 100/7 request completes correctly.
REQ-040 rst low at step 20: all outputs 0 immediately; divide lost; next request completes correctly.
